// File: rtl/sa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_ctrl_pkg
// Purpose  : Shared definitions for the systolic-array instruction sequencer:
//            opcode values, state_signal encodings, the opcode field width,
//            the sequencer FSM state type and an opcode legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package sa_ctrl_pkg;

    // The opcode occupies instr[OPCODE_W-1:0]. All other fields sit above it.
    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_NOP       = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_COMPUTE   = 5'h01;
    localparam logic [OPCODE_W-1:0] OP_COMPUTE_I = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_ACC2OBUF  = 5'h03;
    localparam logic [OPCODE_W-1:0] OP_LD_INP    = 5'h04;
    localparam logic [OPCODE_W-1:0] OP_LD_WT     = 5'h05;
    localparam logic [OPCODE_W-1:0] OP_OBUF_SEND = 5'h06;
    localparam logic [OPCODE_W-1:0] OP_ACC_RST   = 5'h07;
    localparam logic [OPCODE_W-1:0] OP_HALT      = 5'h1F;

    // External state_signal encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_XFER = 2'b01;
    localparam logic [1:0] ST_COMP = 2'b10;

    // Internal sequencer FSM. Transfer is not a separate state: it is a
    // one-cycle output annotation of an accepted load/transfer instruction.
    typedef enum logic [0:0] {
        SEQ_IDLE    = 1'b0,
        SEQ_COMPUTE = 1'b1
    } seq_state_e;

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_NOP, OP_COMPUTE, OP_COMPUTE_I, OP_ACC2OBUF, OP_LD_INP,
            OP_LD_WT, OP_OBUF_SEND, OP_ACC_RST, OP_HALT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module   : sa_instr_field_decode
// Purpose  : Purely combinational slicing of an instruction word into its
//            opcode / address / data fields, plus opcode legality.
// Ports    : instr_i      - full instruction word
//            opcode_o     - instr[4:0]
//            addr_o       - instr[ADDR_W+4:5]
//            data_o       - instr[DATA_W+ADDR_W+4:ADDR_W+5]
//            obuf_addr_o  - low OBUF_ADDR_W bits of addr_o
//            illegal_o    - opcode is not one of the defined opcodes
// Revision : 1.0 - initial release
// ============================================================================
module sa_instr_field_decode
    import sa_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 64,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int OBUF_ADDR_W = 4
) (
    input  logic [INSTR_W-1:0]     instr_i,
    output logic [OPCODE_W-1:0]    opcode_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [OBUF_ADDR_W-1:0] obuf_addr_o,
    output logic                   illegal_o
);

    localparam int USED_W = DATA_W + ADDR_W + OPCODE_W;

    assign opcode_o    = instr_i[OPCODE_W-1:0];
    assign addr_o      = instr_i[ADDR_W+OPCODE_W-1:OPCODE_W];
    assign data_o      = instr_i[USED_W-1:ADDR_W+OPCODE_W];
    assign obuf_addr_o = addr_o[OBUF_ADDR_W-1:0];
    assign illegal_o   = !op_is_legal(opcode_o);

    // Bits above the data field are reserved and deliberately ignored.
    generate
        if (INSTR_W > USED_W) begin : g_reserved_bits
            logic unused_reserved;
            assign unused_reserved = ^instr_i[INSTR_W-1:USED_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sa_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sa_instr_sequencer
// Purpose  : Accepts instructions over valid/ready and turns each into a
//            registered, one-cycle command pulse for the input/weight/output
//            buffers and accumulators. COMPUTE instructions hold the array in
//            the compute state for COMPUTE_CYCLES cycles while back-pressuring
//            the instruction stream. HALT is sticky until reset.
// Ports    : clk, rst (async, active-high)
//            instr / instr_valid / instr_ready      - instruction handshake
//            inp_buf_* / wt_buf_*                   - buffer write commands
//            acc_to_op_buf_addr, acc_result_to_op_buf - accumulator transfer
//            out_buf_addr, op_buffer_instr_for_sending_data - output send
//            instr_for_accum_to_reset               - accumulator clear
//            state_signal (00 idle/01 xfer/10 compute), i_mode
//            compute_done, illegal_op (pulses), halted (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module sa_instr_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int INSTR_W        = 64,
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int OBUF_ADDR_W    = 4,
    parameter int COMPUTE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic [ADDR_W-1:0]      inp_buf_addr,
    output logic [DATA_W-1:0]      inp_buf_data,
    output logic                   inp_buf_we,
    output logic [ADDR_W-1:0]      wt_buf_addr,
    output logic [DATA_W-1:0]      wt_buf_data,
    output logic                   wt_buf_we,
    output logic [OBUF_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                   acc_result_to_op_buf,
    output logic [OBUF_ADDR_W-1:0] out_buf_addr,
    output logic                   op_buffer_instr_for_sending_data,
    output logic                   instr_for_accum_to_reset,
    output logic [1:0]             state_signal,
    output logic                   i_mode,
    output logic                   compute_done,
    output logic                   illegal_op,
    output logic                   halted
);

    localparam int              CNT_W    = $clog2(COMPUTE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [OPCODE_W-1:0]    w_opcode;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;
    logic [OBUF_ADDR_W-1:0] w_obuf_addr;
    logic                   w_illegal;

    sa_instr_field_decode #(
        .INSTR_W     (INSTR_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OBUF_ADDR_W (OBUF_ADDR_W)
    ) u_field_decode (
        .instr_i     (instr),
        .opcode_o    (w_opcode),
        .addr_o      (w_addr),
        .data_o      (w_data),
        .obuf_addr_o (w_obuf_addr),
        .illegal_o   (w_illegal)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   i_mode_q, i_mode_d;
    logic                   halted_q, halted_d;
    logic                   xfer_q, xfer_d;
    logic                   done_q, done_d;
    logic                   illegal_q, illegal_d;
    logic [ADDR_W-1:0]      inp_addr_q, inp_addr_d;
    logic [DATA_W-1:0]      inp_data_q, inp_data_d;
    logic                   inp_we_q, inp_we_d;
    logic [ADDR_W-1:0]      wt_addr_q, wt_addr_d;
    logic [DATA_W-1:0]      wt_data_q, wt_data_d;
    logic                   wt_we_q, wt_we_d;
    logic [OBUF_ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic                   acc_xfer_q, acc_xfer_d;
    logic [OBUF_ADDR_W-1:0] obuf_addr_q, obuf_addr_d;
    logic                   obuf_send_q, obuf_send_d;
    logic                   acc_rst_q, acc_rst_d;

    logic w_accept;

    // rst is included so the handshake is closed during reset even though
    // the registers already show IDLE / not-halted at that point.
    assign instr_ready = !rst && (state_q == SEQ_IDLE) && !halted_q;
    assign w_accept    = instr_valid && instr_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        i_mode_d    = i_mode_q;
        halted_d    = halted_q;
        xfer_d      = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        inp_addr_d  = '0;
        inp_data_d  = '0;
        inp_we_d    = 1'b0;
        wt_addr_d   = '0;
        wt_data_d   = '0;
        wt_we_d     = 1'b0;
        acc_addr_d  = '0;
        acc_xfer_d  = 1'b0;
        obuf_addr_d = '0;
        obuf_send_d = 1'b0;
        acc_rst_d   = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (w_accept) begin
                    illegal_d = w_illegal;
                    case (w_opcode)
                        OP_COMPUTE, OP_COMPUTE_I: begin
                            state_d  = SEQ_COMPUTE;
                            cnt_d    = CNT_LOAD;
                            i_mode_d = (w_opcode == OP_COMPUTE_I);
                        end
                        OP_ACC2OBUF: begin
                            xfer_d     = 1'b1;
                            acc_addr_d = w_obuf_addr;
                            acc_xfer_d = 1'b1;
                        end
                        OP_LD_INP: begin
                            xfer_d     = 1'b1;
                            inp_addr_d = w_addr;
                            inp_data_d = w_data;
                            inp_we_d   = 1'b1;
                        end
                        OP_LD_WT: begin
                            xfer_d    = 1'b1;
                            wt_addr_d = w_addr;
                            wt_data_d = w_data;
                            wt_we_d   = 1'b1;
                        end
                        OP_OBUF_SEND: begin
                            obuf_addr_d = w_obuf_addr;
                            obuf_send_d = 1'b1;
                        end
                        OP_ACC_RST: acc_rst_d = 1'b1;
                        OP_HALT:    halted_d  = 1'b1;
                        default:    ;   // NOP and illegal opcodes
                    endcase
                end
            end
            SEQ_COMPUTE: begin
                // Counter was loaded with COMPUTE_CYCLES-1, so reaching zero
                // marks the last compute cycle; done pulses in the idle cycle.
                if (cnt_q == '0) begin
                    state_d  = SEQ_IDLE;
                    i_mode_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            i_mode_q    <= 1'b0;
            halted_q    <= 1'b0;
            xfer_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            inp_addr_q  <= '0;
            inp_data_q  <= '0;
            inp_we_q    <= 1'b0;
            wt_addr_q   <= '0;
            wt_data_q   <= '0;
            wt_we_q     <= 1'b0;
            acc_addr_q  <= '0;
            acc_xfer_q  <= 1'b0;
            obuf_addr_q <= '0;
            obuf_send_q <= 1'b0;
            acc_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_mode_q    <= i_mode_d;
            halted_q    <= halted_d;
            xfer_q      <= xfer_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            inp_addr_q  <= inp_addr_d;
            inp_data_q  <= inp_data_d;
            inp_we_q    <= inp_we_d;
            wt_addr_q   <= wt_addr_d;
            wt_data_q   <= wt_data_d;
            wt_we_q     <= wt_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_xfer_q  <= acc_xfer_d;
            obuf_addr_q <= obuf_addr_d;
            obuf_send_q <= obuf_send_d;
            acc_rst_q   <= acc_rst_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state_signal = (state_q == SEQ_COMPUTE) ? ST_COMP :
                          (xfer_q ? ST_XFER : ST_IDLE);

    assign i_mode                           = i_mode_q;
    assign compute_done                     = done_q;
    assign illegal_op                       = illegal_q;
    assign halted                           = halted_q;
    assign inp_buf_addr                     = inp_addr_q;
    assign inp_buf_data                     = inp_data_q;
    assign inp_buf_we                       = inp_we_q;
    assign wt_buf_addr                      = wt_addr_q;
    assign wt_buf_data                      = wt_data_q;
    assign wt_buf_we                        = wt_we_q;
    assign acc_to_op_buf_addr               = acc_addr_q;
    assign acc_result_to_op_buf             = acc_xfer_q;
    assign out_buf_addr                     = obuf_addr_q;
    assign op_buffer_instr_for_sending_data = obuf_send_q;
    assign instr_for_accum_to_reset         = acc_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_instr_sequencer
// Purpose  : Directed self-checking bench for sa_instr_sequencer with default
//            parameters (COMPUTE_CYCLES = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_instr_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  inp_buf_addr;
    logic [31:0] inp_buf_data;
    logic        inp_buf_we;
    logic [6:0]  wt_buf_addr;
    logic [31:0] wt_buf_data;
    logic        wt_buf_we;
    logic [3:0]  acc_to_op_buf_addr;
    logic        acc_result_to_op_buf;
    logic [3:0]  out_buf_addr;
    logic        op_buffer_instr_for_sending_data;
    logic        instr_for_accum_to_reset;
    logic [1:0]  state_signal;
    logic        i_mode;
    logic        compute_done;
    logic        illegal_op;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    sa_instr_sequencer #(
        .INSTR_W        (64),
        .ADDR_W         (7),
        .DATA_W         (32),
        .OBUF_ADDR_W    (4),
        .COMPUTE_CYCLES (16)
    ) u_dut (
        .clk                              (clk),
        .rst                              (rst),
        .instr                            (instr),
        .instr_valid                      (instr_valid),
        .instr_ready                      (instr_ready),
        .inp_buf_addr                     (inp_buf_addr),
        .inp_buf_data                     (inp_buf_data),
        .inp_buf_we                       (inp_buf_we),
        .wt_buf_addr                      (wt_buf_addr),
        .wt_buf_data                      (wt_buf_data),
        .wt_buf_we                        (wt_buf_we),
        .acc_to_op_buf_addr               (acc_to_op_buf_addr),
        .acc_result_to_op_buf             (acc_result_to_op_buf),
        .out_buf_addr                     (out_buf_addr),
        .op_buffer_instr_for_sending_data (op_buffer_instr_for_sending_data),
        .instr_for_accum_to_reset         (instr_for_accum_to_reset),
        .state_signal                     (state_signal),
        .i_mode                           (i_mode),
        .compute_done                     (compute_done),
        .illegal_op                       (illegal_op),
        .halted                           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All command outputs except instr_ready/halted, packed for whole-bus compares
    logic [95:0] w_all;
    assign w_all = {inp_buf_addr, inp_buf_data, inp_buf_we,
                    wt_buf_addr, wt_buf_data, wt_buf_we,
                    acc_to_op_buf_addr, acc_result_to_op_buf,
                    out_buf_addr, op_buffer_instr_for_sending_data,
                    instr_for_accum_to_reset, state_signal, i_mode,
                    compute_done, illegal_op};

    function automatic logic [95:0] pack(
        input logic [6:0] ia, input logic [31:0] id, input logic iwe,
        input logic [6:0] wa, input logic [31:0] wd, input logic wwe,
        input logic [3:0] aa, input logic ax,
        input logic [3:0] oa, input logic os,
        input logic ar, input logic [1:0] st, input logic im,
        input logic cd, input logic il);
        return {ia, id, iwe, wa, wd, wwe, aa, ax, oa, os, ar, st, im, cd, il};
    endfunction

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [6:0] a,
                                       input logic [31:0] d);
        return {20'h0, d, a, op};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [95:0] ZERO;
    logic [95:0] COMP_I;
    logic [95:0] COMP_N;

    initial begin
        ZERO   = '0;
        COMP_I = pack(0,0,0, 0,0,0, 0,0, 0,0, 0, 2'b10, 1, 0, 0);
        COMP_N = pack(0,0,0, 0,0,0, 0,0, 0,0, 0, 2'b10, 0, 0, 0);

        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;

        // ---------------- reset ----------------
        cyc(); cyc();
        chk("reset_outputs", w_all, ZERO);
        chk("reset_halted", halted, 1'b0);
        chk("reset_ready", instr_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", instr_ready, 1'b1);

        // ---------------- LD_INP ----------------
        instr = mk(5'h04, 7'h5A, 32'hDEADBEEF);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("ld_inp", w_all, pack(7'h5A, 32'hDEADBEEF, 1, 0,0,0, 0,0, 0,0, 0, 2'b01, 0,0,0));
        cyc();
        chk("ld_inp_gone", w_all, ZERO);

        // ---------------- COMPUTE_I with a queued LD_WT ----------------
        instr = mk(5'h02, 7'h00, 32'h0);
        instr_valid = 1'b1;
        cyc();
        instr = mk(5'h05, 7'h11, 32'h12345678);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("comp_i_c%0d", k), w_all, COMP_I);
            chk($sformatf("comp_i_ready_c%0d", k), instr_ready, 1'b0);
            cyc();
        end
        chk("comp_i_done", w_all, pack(0,0,0, 0,0,0, 0,0, 0,0, 0, 2'b00, 0, 1, 0));
        chk("comp_i_ready_back", instr_ready, 1'b1);
        cyc();
        instr_valid = 1'b0;
        chk("queued_ld_wt", w_all, pack(0,0,0, 7'h11, 32'h12345678, 1, 0,0, 0,0, 0, 2'b01, 0,0,0));

        // ---------------- back-to-back 05, 03, 06, 07 ----------------
        instr = mk(5'h05, 7'h22, 32'hA5A5A5A5);
        instr_valid = 1'b1;
        cyc();
        instr = mk(5'h03, 7'h03, 32'h0);
        chk("b2b_ld_wt", w_all, pack(0,0,0, 7'h22, 32'hA5A5A5A5, 1, 0,0, 0,0, 0, 2'b01, 0,0,0));
        chk("b2b_ready", instr_ready, 1'b1);
        cyc();
        instr = mk(5'h06, 7'h79, 32'hFFFFFFFF);
        chk("b2b_acc2obuf", w_all, pack(0,0,0, 0,0,0, 4'h3, 1, 0,0, 0, 2'b01, 0,0,0));
        cyc();
        instr = mk(5'h07, 7'h7F, 32'h0);
        chk("b2b_obuf_send", w_all, pack(0,0,0, 0,0,0, 0,0, 4'h9, 1, 0, 2'b00, 0,0,0));
        cyc();
        instr_valid = 1'b0;
        chk("b2b_acc_rst", w_all, pack(0,0,0, 0,0,0, 0,0, 0,0, 1, 2'b00, 0,0,0));
        cyc();
        chk("b2b_quiet", w_all, ZERO);

        // ---------------- illegal, NOP, HALT ----------------
        instr = mk(5'h15, 7'h12, 32'h11111111);
        instr_valid = 1'b1;
        cyc();
        instr = mk(5'h00, 7'h55, 32'h22222222);
        chk("illegal_pulse", w_all, pack(0,0,0, 0,0,0, 0,0, 0,0, 0, 2'b00, 0, 0, 1));
        cyc();
        instr = mk(5'h1F, 7'h00, 32'h0);
        chk("nop_quiet", w_all, ZERO);
        cyc();
        instr = mk(5'h04, 7'h33, 32'h33333333);
        chk("halt_outputs", w_all, ZERO);
        chk("halt_set", halted, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("halt_ready_c%0d", k), instr_ready, 1'b0);
            cyc();
        end
        chk("halt_ignored_cmds", w_all, ZERO);
        chk("halt_sticky", halted, 1'b1);
        instr_valid = 1'b0;

        // ---------------- reset clears HALT ----------------
        rst = 1'b1;
        #1;
        chk("rst_clears_halt", halted, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("ready_after_halt_rst", instr_ready, 1'b1);

        // ---------------- reset mid-COMPUTE ----------------
        instr = mk(5'h01, 7'h00, 32'h0);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("comp_c5", w_all, COMP_N);
        rst = 1'b1;
        #1;
        chk("midcomp_rst_outputs", w_all, ZERO);
        chk("midcomp_rst_ready", instr_ready, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        chk("midcomp_ready_after", instr_ready, 1'b1);

        // ---------------- full COMPUTE after reset ----------------
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("comp_c%0d", k), w_all, COMP_N);
            chk($sformatf("comp_ready_c%0d", k), instr_ready, 1'b0);
            cyc();
        end
        chk("comp_done", w_all, pack(0,0,0, 0,0,0, 0,0, 0,0, 0, 2'b00, 0, 1, 0));
        chk("comp_ready_back", instr_ready, 1'b1);
        cyc();
        chk("comp_done_one_cycle", w_all, ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_instr_sequencer.md
# sa_instr_sequencer

Parametrised instruction sequencer for the systolic-array datapath, successor to the single-cycle opcode controller. It accepts 64-bit instructions over a valid/ready handshake and decodes them into registered one-cycle command pulses for the input, weight and output buffers and the accumulators. It holds the array in the compute state for a programmable number of cycles, applying back-pressure meanwhile. It also supports a sticky HALT and flags illegal opcodes.

## Interface
Parameters:
- INSTR_W, 64, instruction width; must be ≥ DATA_W+ADDR_W+5
- ADDR_W, 7, input/weight buffer address width
- DATA_W, 32, buffer write-data width
- OBUF_ADDR_W, 4, output-buffer / accumulator address width; ≤ ADDR_W
- COMPUTE_CYCLES, 16, cycles the array stays in compute per COMPUTE instruction; ≥ 1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  INSTR_W  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer can accept an instruction
- inp_buf_addr / inp_buf_data / inp_buf_we  out  ADDR_W / DATA_W / 1  input-buffer write
- wt_buf_addr / wt_buf_data / wt_buf_we  out  ADDR_W / DATA_W / 1  weight-buffer write
- acc_to_op_buf_addr  out  OBUF_ADDR_W  accumulator row to transfer
- acc_result_to_op_buf  out  1  accumulator→output-buffer transfer strobe
- out_buf_addr  out  OBUF_ADDR_W  output-buffer row to send
- op_buffer_instr_for_sending_data  out  1  output-buffer send strobe
- instr_for_accum_to_reset  out  1  accumulator clear strobe
- state_signal  out  2  00 idle, 01 transfer, 10 compute
- i_mode  out  1  input-stationary mode; valid while state_signal=10
- compute_done  out  1  one-cycle pulse after the last compute cycle
- illegal_op  out  1  one-cycle pulse for an unknown opcode
- halted  out  1  sticky; set by HALT

## Operation
- Fields: opcode = instr[4:0]; addr = instr[ADDR_W+4:5]; data = instr[DATA_W+ADDR_W+4:ADDR_W+5]. With default parameters, addr = [11:5] and data = [43:12].
- Accept occurs when instr_valid & instr_ready at a rising edge.
- instr_ready = !rst & (fsm==IDLE) & !halted.
- FSM states: IDLE and COMPUTE.
- Opcode actions (every strobe lasts one cycle; unlisted outputs are 0):
  - 00 NOP: no action.
  - 01 COMPUTE: go to COMPUTE, i_mode=0.
  - 02 COMPUTE_I: go to COMPUTE, i_mode=1.
  - 03: state_signal=01, acc_to_op_buf_addr=addr[OBUF_ADDR_W-1:0], acc_result_to_op_buf=1.
  - 04: state_signal=01, inp_buf_addr=addr, inp_buf_data=data, inp_buf_we=1.
  - 05: state_signal=01, wt_buf_addr=addr, wt_buf_data=data, wt_buf_we=1.
  - 06: out_buf_addr=addr[OBUF_ADDR_W-1:0], op_buffer_instr_for_sending_data=1.
  - 07: instr_for_accum_to_reset=1.
  - 1F HALT: set halted; instr_ready drops until reset.
  - Any other opcode: illegal_op=1, otherwise treated as NOP.
- COMPUTE state:
  - Down-counter width $clog2(COMPUTE_CYCLES+1), loaded with COMPUTE_CYCLES-1 on accept.
  - state_signal=10 and i_mode held throughout; decrements each cycle.
  - At count 0 the FSM returns to IDLE and compute_done pulses the next cycle.
- With no accept, all strobes, addr/data outputs and state_signal are 0. i_mode is 0 outside COMPUTE.

## Timing
- Reset value of every output is 0, including halted, compute_done and illegal_op. instr_ready is 0 while rst is high.
- Reset takes effect immediately, including mid-COMPUTE: counter cleared, FSM to IDLE, halted cleared. instr_ready rises in the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N drives its outputs during cycle N+1 (registered, one cycle wide).
- COMPUTE accepted at edge N:
  - state_signal=10 for cycles N+1 … N+COMPUTE_CYCLES, with instr_ready=0.
  - compute_done=1 and instr_ready=1 in cycle N+COMPUTE_CYCLES+1.
  - Earliest next accept is edge N+COMPUTE_CYCLES+1.
- Back-to-back non-compute instructions are accepted every cycle, giving 100% throughput.
- instr_valid while instr_ready=0 is ignored; instr is not sampled.
- COMPUTE_CYCLES=1 gives exactly one compute cycle.

## Structure
- Shared package sa_ctrl_pkg holds:
  - opcode localparams (OP_NOP, OP_COMPUTE, OP_COMPUTE_I, OP_ACC2OBUF, OP_LD_INP, OP_LD_WT, OP_OBUF_SEND, OP_ACC_RST, OP_HALT);
  - state_signal encodings (ST_IDLE=2'b00, ST_XFER=2'b01, ST_COMP=2'b10);
  - the field offset OPCODE_W=5.
- One sub-module, sa_instr_field_decode: combinational field slicing plus opcode legality. The top level holds the FSM, the counter and the output registers.

## Test plan
- Reset then LD_INP with opcode 04, addr 7'h5A, data 32'hDEADBEEF → cycle N+1: inp_buf_we=1, inp_buf_addr=5A, inp_buf_data=DEADBEEF, state_signal=01; cycle N+2 all 0.
- COMPUTE_I with COMPUTE_CYCLES=16 and instr_valid held high → state_signal=10, i_mode=1 for 16 cycles with instr_ready=0; compute_done and instr_ready at cycle 17; the queued LD_WT is accepted at edge 17.
- Back-to-back 05, 03 (addr 3), 06 (addr 9), 07 over four cycles → each strobe appears exactly once, one cycle after its accept, with correct 4-bit addresses.
- Opcode 5'b10101 → illegal_op pulse only; a following NOP, then HALT → halted=1 and instr_ready=0 for 20 further valid cycles.
- Assert rst at cycle 5 of a COMPUTE → all outputs 0 immediately; instr_ready=1 the cycle after deassert; a new COMPUTE then runs the full 16 cycles.
